fetch_decode_unit: RTL and testbench

Parametrised instruction fetch and decode front end for the RISC-V core. It owns the program counter and fetches 32-bit instructions from instruction memory over a request/acknowledge handshake. It decodes register fields and sign-extended immediates for every RV64I format and hands each instruction to the datapath over a valid/ready interface. It accepts PC redirects from branch/jump resolution and halts on illegal instructions or misaligned targets.

---
 rtl/fetch_decode_unit_pkg.sv | 54 +++++
 rtl/fetch_decode_unit_if.sv | 41 ++++
 rtl/fetch_decode_unit_imm_gen.sv | 38 +++
 rtl/fetch_decode_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_decode_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_unit_pkg.sv
// Shared definitions for the instruction fetch/decode front end.
//   - RV64I base opcode constants
//   - FSM state encoding and error-cause encoding
//   - immediate format classification helper
package fetch_decode_unit_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FLUSH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ILLEGAL  = 2'b01,
    ERR_MISALIGN = 2'b10
  } err_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_t;

  function automatic fmt_t opcode_fmt(input logic [6:0] op);
    case (op)
      OP_IMM, OP_IMM_32, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                            return FMT_S;
      OP_BRANCH:                           return FMT_B;
      OP_LUI, OP_AUIPC:                    return FMT_U;
      OP_JAL:                              return FMT_J;
      OP_OP, OP_OP_32:                     return FMT_R;
      default:                             return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Bus bundle between the fetch/decode front end, instruction memory and
// the datapath.
//   im_*       : instruction memory request/acknowledge channel
//   dec_*, fields, imm : decoded instruction, valid/ready handshake
//   redirect*  : PC redirect from branch/jump resolution
// master = fetch/decode unit, slave = memory + datapath side.
interface fetch_decode_unit_if #(
  parameter int XLEN = 64
);
  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic            im_ack;
  logic [31:0]     im_rdata;

  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;

  logic            redirect;
  logic [XLEN-1:0] redirect_addr;

  modport master (
    output im_req, im_addr, dec_valid, dec_pc, opcode, funct3, funct7,
           rs1, rs2, rd, imm,
    input  im_ack, im_rdata, dec_ready, redirect, redirect_addr
  );

  modport slave (
    input  im_req, im_addr, dec_valid, dec_pc, opcode, funct3, funct7,
           rs1, rs2, rd, imm,
    output im_ack, im_rdata, dec_ready, redirect, redirect_addr
  );

endinterface

// File: rtl/fetch_decode_unit_imm_gen.sv
// Combinational immediate generator.
//   inst  : 32-bit instruction word
//   imm   : sign-extended immediate (XLEN bits), 0 for R-type
//   legal : 1 when the opcode is a supported RV64I format
module imm_gen
  import fetch_decode_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]             inst,
  output logic signed [XLEN-1:0]  imm,
  output logic                    legal
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    legal = 1'b1;
    case (opcode_fmt(inst[6:0]))
      FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                        inst[11:8], 1'b0};
      FMT_U:   imm32 = {inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                        inst[30:21], 1'b0};
      FMT_R:   imm32 = '0;
      default: legal = 1'b0;
    endcase
    // Compressed/reserved encodings never reach the decoder as legal.
    if (inst[1:0] != 2'b11) legal = 1'b0;
  end

  // Size cast of a signed operand sign-extends to XLEN.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction fetch and decode front end.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : master side of fetch_decode_unit_if (memory fetch channel,
//                decoded-instruction handshake, PC redirect)
//   halted     : unit stopped on an error, only reset restarts it
//   err_cause  : 00 none, 01 illegal instruction, 10 misaligned redirect
// One instruction is in flight at a time: FETCH -> ISSUE -> FETCH. FLUSH
// waits out a memory response whose address was invalidated by a redirect.
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_decode_unit_if.master  bus,
  output logic                 halted,
  output logic [1:0]           err_cause
);

  state_t                 state;
  logic [XLEN-1:0]        pc;
  logic [XLEN-1:0]        req_addr;
  logic                   req;
  err_t                   err;

  logic [31:0]            inst_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [XLEN-1:0]        pc_p1;
  logic                   vld_p1;

  logic signed [XLEN-1:0] imm_new;
  logic                   legal_new;
  logic                   ack;
  logic                   redir_bad;
  logic [XLEN-1:0]        pc_inc;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst  (bus.im_rdata),
    .imm   (imm_new),
    .legal (legal_new)
  );

  // An acknowledge only counts against a request we actually raised.
  assign ack       = bus.im_ack && req;
  assign redir_bad = bus.redirect && (bus.redirect_addr[1:0] != 2'b00);
  assign pc_inc    = pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_ADDR;
      req_addr <= RESET_ADDR;
      req      <= 1'b0;
      halted   <= 1'b0;
      err      <= ERR_NONE;
      inst_p1  <= '0;
      imm_p1   <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          req <= 1'b1;
          if (redir_bad) begin
            state  <= S_HALT;
            req    <= 1'b0;
            halted <= 1'b1;
            err    <= ERR_MISALIGN;
          end else if (bus.redirect) begin
            pc <= bus.redirect_addr;
            // Without the ack the old request is still outstanding; keep
            // presenting its address until memory answers, then drop it.
            if (!ack) begin
              state    <= S_FLUSH;
              req_addr <= pc;
            end
          end else if (ack) begin
            if (legal_new) begin
              // Fetch -> issue stage boundary
              inst_p1 <= bus.im_rdata;
              imm_p1  <= imm_new;
              pc_p1   <= pc;
              vld_p1  <= 1'b1;
              req     <= 1'b0;
              state   <= S_ISSUE;
            end else begin
              state  <= S_HALT;
              req    <= 1'b0;
              halted <= 1'b1;
              err    <= ERR_ILLEGAL;
            end
          end
        end

        S_FLUSH: begin
          if (redir_bad) begin
            state  <= S_HALT;
            req    <= 1'b0;
            halted <= 1'b1;
            err    <= ERR_MISALIGN;
          end else begin
            if (bus.redirect) pc <= bus.redirect_addr;
            if (ack) state <= S_FETCH;
          end
        end

        S_ISSUE: begin
          if (redir_bad) begin
            state  <= S_HALT;
            vld_p1 <= 1'b0;
            halted <= 1'b1;
            err    <= ERR_MISALIGN;
          end else if (bus.redirect) begin
            // Redirect takes priority over pc+4 even when the datapath
            // accepts the instruction in the same cycle.
            pc     <= bus.redirect_addr;
            vld_p1 <= 1'b0;
            req    <= 1'b1;
            state  <= S_FETCH;
          end else if (bus.dec_ready) begin
            pc     <= pc_inc;
            vld_p1 <= 1'b0;
            req    <= 1'b1;
            state  <= S_FETCH;
          end
        end

        S_HALT: begin
        end
      endcase
    end
  end

  assign bus.im_req    = req;
  assign bus.im_addr   = (state == S_FLUSH) ? req_addr : pc;
  assign bus.dec_valid = vld_p1;
  assign bus.dec_pc    = pc_p1;
  assign bus.opcode    = inst_p1[6:0];
  assign bus.rd        = inst_p1[11:7];
  assign bus.funct3    = inst_p1[14:12];
  assign bus.rs1       = inst_p1[19:15];
  assign bus.rs2       = inst_p1[24:20];
  assign bus.funct7    = inst_p1[31:25];
  assign bus.imm       = imm_p1;
  assign err_cause     = err;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Testbench for fetch_decode_unit: directed scenarios plus a randomized run,
// checked against a transaction-level model of the program counter flow.
module tb_fetch_decode_unit;

  localparam int          XLEN = 64;
  localparam logic [63:0] RST_A = 64'h100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halted;
  logic [1:0] err_cause;

  fetch_decode_unit_if #(.XLEN(XLEN)) bus ();

  fetch_decode_unit #(.XLEN(XLEN), .RESET_ADDR(RST_A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .halted    (halted),
    .err_cause (err_cause)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023];

  // stimulus knobs
  int          ack_fixed = 0;
  int          rdy_mode = 1;
  int          redir_pct = 0;
  bit          force_redir = 0;
  logic [63:0] force_addr = '0;
  int          wait_cnt = 0;
  int          cur_dly = 0;

  // reference model state
  logic [63:0] exp_pc = RST_A;
  logic [63:0] stale_addr = '0;
  bit          have_insn = 0;
  bit          flushing = 0;
  bit          exp_halt = 0;
  bit          model_on = 0;
  logic [1:0]  exp_err = 2'b00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, got, want);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [63:0] a);
    return mem[a[11:2]];
  endfunction

  function automatic bit ref_legal(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63,
      7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Immediate value computed arithmetically from the instruction fields.
  function automatic longint ref_imm(input logic [31:0] w);
    int s;
    s = int'(w);
    case (w[6:0])
      7'h13, 7'h1B, 7'h03, 7'h67: return longint'(s >>> 20);
      7'h23: return longint'((s >>> 25) * 32 + ((s >> 7) & 31));
      7'h63: return longint'((s >>> 31) * 4096 + ((s >> 7) & 1) * 2048 +
                             ((s >> 25) & 63) * 32 + ((s >> 8) & 15) * 2);
      7'h37, 7'h17: return longint'(s & -4096);
      7'h6F: return longint'((s >>> 31) * 1048576 + ((s >> 12) & 255) * 4096 +
                             ((s >> 20) & 1) * 2048 + ((s >> 21) & 1023) * 2);
      default: return 64'sd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h13;
      1: w[6:0] = 7'h1B;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h23;
      5: w[6:0] = 7'h63;
      6: w[6:0] = 7'h37;
      7: w[6:0] = 7'h17;
      8: w[6:0] = 7'h6F;
      9: w[6:0] = 7'h33;
      default: w[6:0] = 7'h3B;
    endcase
    return w;
  endfunction

  // One clock: check outputs, drive memory/datapath inputs, advance model.
  task automatic cycle();
    logic [31:0] w;
    bit hs;
    @(posedge clk);
    #1;
    if (model_on) begin
      if (exp_halt) begin
        check("halted", 64'(halted), 64'(1));
        check("err_cause", 64'(err_cause), 64'(exp_err));
        check("halt_req", 64'(bus.im_req), 64'(0));
        check("halt_valid", 64'(bus.dec_valid), 64'(0));
      end else begin
        check("not_halted", 64'(halted), 64'(0));
        check("dec_valid", 64'(bus.dec_valid), 64'(have_insn));
        check("im_req", 64'(bus.im_req), 64'(!have_insn));
        if (have_insn) begin
          w = rd_mem(exp_pc);
          check("dec_pc", bus.dec_pc, exp_pc);
          check("fields", 64'({bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode}), 64'(w));
          check("imm", bus.imm, ref_imm(w));
        end else begin
          check("im_addr", bus.im_addr, flushing ? stale_addr : exp_pc);
        end
      end
    end
    // instruction memory responder
    if (bus.im_req) begin
      if (wait_cnt >= ((ack_fixed >= 0) ? ack_fixed : cur_dly)) begin
        bus.im_ack   = 1'b1;
        bus.im_rdata = rd_mem(bus.im_addr);
        wait_cnt     = 0;
        cur_dly      = $urandom_range(0, 3);
      end else begin
        bus.im_ack   = 1'b0;
        bus.im_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      bus.im_ack = 1'b0;
      wait_cnt   = 0;
    end
    // datapath side
    case (rdy_mode)
      1:       bus.dec_ready = 1'b1;
      2:       bus.dec_ready = 1'b0;
      default: bus.dec_ready = ($urandom_range(0, 9) < 7);
    endcase
    if (force_redir) begin
      bus.redirect      = 1'b1;
      bus.redirect_addr = force_addr;
      force_redir       = 0;
    end else if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) begin
      bus.redirect      = 1'b1;
      bus.redirect_addr = {52'b0, 10'($urandom), 2'b00};
    end else begin
      bus.redirect      = 1'b0;
      bus.redirect_addr = {$urandom, $urandom};
    end
    // model: what the next edge does to the program flow
    if (model_on && !exp_halt) begin
      hs = have_insn && bus.dec_ready;
      if (bus.redirect) begin
        if (bus.redirect_addr[1:0] != 2'b00) begin
          exp_halt = 1;
          exp_err  = 2'b10;
        end else begin
          if (!have_insn) begin
            if (bus.im_ack) flushing = 0;
            else if (!flushing) begin
              flushing   = 1;
              stale_addr = exp_pc;
            end
          end
          have_insn = 0;
          exp_pc    = bus.redirect_addr;
        end
      end else if (hs) begin
        have_insn = 0;
        exp_pc    = exp_pc + 64'd4;
      end else if (!have_insn && bus.im_ack) begin
        if (flushing) flushing = 0;
        else if (ref_legal(rd_mem(exp_pc))) have_insn = 1;
        else begin
          exp_halt = 1;
          exp_err  = 2'b01;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req", 64'(bus.im_req), 64'(0));
    check("rst_valid", 64'(bus.dec_valid), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_err", 64'(err_cause), 64'(0));
    check("rst_fields", 64'({bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode}), 64'(0));
    check("rst_imm", bus.imm, 64'(0));
    check("rst_dec_pc", bus.dec_pc, 64'(0));
    bus.im_ack    = 1'b0;
    bus.dec_ready = 1'b0;
    bus.redirect  = 1'b0;
    wait_cnt      = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_pc    = RST_A;
    have_insn = 0;
    flushing  = 0;
    exp_halt  = 0;
    exp_err   = 2'b00;
    model_on  = 1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.dec_valid && n < 30);
    if (!bus.dec_valid) check(tag, 64'(bus.dec_valid), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] tp_imm [5];
    logic [31:0] snap;
    logic [63:0] snap_imm;
    int n;

    bus.im_ack        = 1'b0;
    bus.im_rdata      = '0;
    bus.dec_ready     = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;

    for (int i = 0; i < 1024; i++) mem[i] = rand_insn();
    mem[64] = 32'hFFB00093;  // addi x1,x0,-5
    mem[65] = 32'hFE20AC23;  // sw x2,-8(x1)
    mem[66] = 32'hFE000EE3;  // beq offset -4
    mem[67] = 32'h0010006F;  // jal +2048
    mem[68] = 32'h123452B7;  // lui 0x12345
    tp_imm[0] = 64'hFFFF_FFFF_FFFF_FFFB;
    tp_imm[1] = 64'hFFFF_FFFF_FFFF_FFF8;
    tp_imm[2] = 64'hFFFF_FFFF_FFFF_FFFC;
    tp_imm[3] = 64'h0000_0000_0000_0800;
    tp_imm[4] = 64'h0000_0000_1234_5000;

    // reset, then straight-line fetch with single-cycle ack and ready held
    ack_fixed = 0;
    rdy_mode  = 1;
    do_reset();
    cycle();
    check("first_req", 64'(bus.im_req), 64'(1));
    check("first_addr", bus.im_addr, RST_A);
    for (int k = 0; k < 5; k++) begin
      wait_valid("tp_valid");
      check("tp_imm", bus.imm, tp_imm[k]);
      if (k == 0) begin
        check("tp_pc", bus.dec_pc, RST_A);
        check("tp_rd", 64'(bus.rd), 64'(1));
        cycle();
        check("tp_next_req", 64'(bus.im_req), 64'(1));
        check("tp_next_addr", bus.im_addr, 64'h104);
      end
    end

    // datapath stalls: outputs hold, no new request
    rdy_mode = 2;
    wait_valid("stall_valid");
    snap     = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
    snap_imm = bus.imm;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("stall_valid_hold", 64'(bus.dec_valid), 64'(1));
      check("stall_fields", 64'({bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode}), 64'(snap));
      check("stall_imm", bus.imm, snap_imm);
      check("stall_no_req", 64'(bus.im_req), 64'(0));
    end

    // redirect while the memory ack is 3 cycles late
    rdy_mode  = 1;
    ack_fixed = 3;
    wait_valid("pre_redir_valid");
    cycle();
    force_redir = 1;
    force_addr  = 64'h200;
    cycle();
    wait_valid("redir_valid");
    check("redir_pc", bus.dec_pc, 64'h200);

    // redirect coincident with the issue handshake
    ack_fixed = 0;
    rdy_mode  = 2;
    wait_valid("coinc_valid");
    rdy_mode    = 1;
    force_redir = 1;
    force_addr  = 64'h300;
    cycle();
    cycle();
    check("coinc_req_addr", bus.im_addr, 64'h300);
    wait_valid("coinc_valid2");
    check("coinc_pc", bus.dec_pc, 64'h300);
    wait_valid("coinc_valid3");
    check("coinc_pc_next", bus.dec_pc, 64'h304);

    // illegal instruction halts; redirect ignored; reset restarts
    mem[256]    = 32'hFFFF_FFFF;
    force_redir = 1;
    force_addr  = 64'h400;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!halted && n < 20);
    check("illegal_halted", 64'(halted), 64'(1));
    check("illegal_cause", 64'(err_cause), 64'(1));
    force_redir = 1;
    force_addr  = 64'h500;
    repeat (4) cycle();
    check("halt_ignores_redir", 64'(bus.im_req), 64'(0));
    do_reset();
    cycle();
    check("restart_addr", bus.im_addr, RST_A);
    mem[256] = rand_insn();

    // misaligned redirect straight after reset
    force_redir = 1;
    force_addr  = 64'h202;
    repeat (3) cycle();
    check("misalign_halted", 64'(halted), 64'(1));
    check("misalign_cause", 64'(err_cause), 64'(2));
    do_reset();

    // randomized traffic
    ack_fixed = -1;
    rdy_mode  = 0;
    redir_pct = 4;
    repeat (3000) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
